// File: rtl/vec_elem_seq_if.sv
// Descriptor and element channels of the vector element sequencer.
// The slave view belongs to the sequencer; the master view is the issue
// logic that feeds it together with the lane pipeline that consumes elements.
interface vec_elem_seq_if #(
  parameter int VL_W    = 6,
  parameter int IDX_W   = 5,
  parameter int RADDR_W = 5,
  parameter int OP_W    = 4
);
  logic               req_valid;
  logic               req_ready;
  logic [VL_W-1:0]    req_vl;
  logic [RADDR_W-1:0] req_vd;
  logic [RADDR_W-1:0] req_vs1;
  logic [RADDR_W-1:0] req_vs2;
  logic [OP_W-1:0]    req_op;

  logic               el_valid;
  logic               el_ready;
  logic [IDX_W-1:0]   el_idx;
  logic [RADDR_W-1:0] el_vd;
  logic [RADDR_W-1:0] el_vs1;
  logic [RADDR_W-1:0] el_vs2;
  logic [OP_W-1:0]    el_op;
  logic               el_last;

  logic               done;
  logic               busy;

  modport slave (
    input  req_valid, req_vl, req_vd, req_vs1, req_vs2, req_op, el_ready,
    output req_ready, el_valid, el_idx, el_vd, el_vs1, el_vs2, el_op, el_last,
           done, busy
  );

  modport master (
    output req_valid, req_vl, req_vd, req_vs1, req_vs2, req_op, el_ready,
    input  req_ready, el_valid, el_idx, el_vd, el_vs1, el_vs2, el_op, el_last,
           done, busy
  );
endinterface

// File: rtl/vec_elem_seq.sv
// Vector element sequencer: takes one instruction descriptor, issues its
// elements one per cycle into the lane pipeline (stalling on el_ready), then
// waits for the lane pipeline to drain and pulses done for one cycle.
// Every output is driven straight from a register.
module vec_elem_seq #(
  parameter int MAXVL      = 32,
  parameter int VL_W       = 6,
  parameter int IDX_W      = 5,
  parameter int RADDR_W    = 5,
  parameter int OP_W       = 4,
  parameter int PIPE_DEPTH = 3
) (
  input  logic           clk,
  input  logic           reset,
  vec_elem_seq_if.slave  bus
);

  // One spare bit so the "next cycle is the last" compare against 2 is
  // meaningful even when PIPE_DEPTH is 1.
  localparam int CNT_W = $clog2(PIPE_DEPTH + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t             state;
  logic [VL_W-1:0]    vl_eff;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic               req_ready_r;
  logic               el_valid_r;
  logic               el_last_r;
  logic               done_r;
  logic               busy_r;
  logic [RADDR_W-1:0] vd_r;
  logic [RADDR_W-1:0] vs1_r;
  logic [RADDR_W-1:0] vs2_r;
  logic [OP_W-1:0]    op_r;

  // Saturate the requested length to the longest vector the unit supports.
  function automatic logic [VL_W-1:0] clamp_vl(input logic [VL_W-1:0] vl);
    if (vl > VL_W'(MAXVL)) return VL_W'(MAXVL);
    return vl;
  endfunction

  logic [VL_W-1:0] req_vl_eff;
  logic [VL_W-1:0] idx_ext;
  logic [VL_W-1:0] idx_next_ext;
  logic [VL_W-1:0] last_idx;
  logic            at_last;

  assign req_vl_eff   = clamp_vl(bus.req_vl);
  assign idx_ext      = VL_W'(idx);
  assign idx_next_ext = idx_ext + VL_W'(1);
  assign last_idx     = vl_eff - VL_W'(1);
  assign at_last      = (idx_ext == last_idx);

  // Control FSM with all outputs registered; el_last is precomputed for the
  // element about to be presented so it never depends on el_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      vl_eff      <= '0;
      idx         <= '0;
      cnt         <= '0;
      req_ready_r <= 1'b1;
      el_valid_r  <= 1'b0;
      el_last_r   <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      vd_r        <= '0;
      vs1_r       <= '0;
      vs2_r       <= '0;
      op_r        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            vd_r        <= bus.req_vd;
            vs1_r       <= bus.req_vs1;
            vs2_r       <= bus.req_vs2;
            op_r        <= bus.req_op;
            vl_eff      <= req_vl_eff;
            idx         <= '0;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (req_vl_eff != '0) begin
              state      <= ISSUE;
              el_valid_r <= 1'b1;
              el_last_r  <= (req_vl_eff == VL_W'(1));
            end else begin
              // Empty instruction: nothing to issue, complete next cycle.
              state  <= DRAIN;
              cnt    <= CNT_W'(1);
              done_r <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (bus.el_ready) begin
            if (at_last) begin
              state      <= DRAIN;
              cnt        <= CNT_W'(PIPE_DEPTH);
              done_r     <= (PIPE_DEPTH == 1);
              el_valid_r <= 1'b0;
              el_last_r  <= 1'b0;
            end else begin
              idx       <= idx + IDX_W'(1);
              el_last_r <= (idx_next_ext == last_idx);
            end
          end
        end
        DRAIN: begin
          if (cnt == CNT_W'(1)) begin
            state       <= IDLE;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            req_ready_r <= 1'b1;
          end else begin
            cnt    <= cnt - CNT_W'(1);
            done_r <= (cnt == CNT_W'(2));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.el_valid  = el_valid_r;
  assign bus.el_idx    = idx;
  assign bus.el_vd     = vd_r;
  assign bus.el_vs1    = vs1_r;
  assign bus.el_vs2    = vs2_r;
  assign bus.el_op     = op_r;
  assign bus.el_last   = el_last_r;
  assign bus.done      = done_r;
  assign bus.busy      = busy_r;

endmodule

// File: doc/vec_elem_seq.md
# vec_elem_seq

Element sequencer for the vector unit: accepts one vector instruction descriptor over a valid/ready handshake and issues its elements, one per cycle, into the lane pipeline built from segment registers. It throttles on a downstream ready and tracks pipeline drain. It emits a single-cycle completion pulse once the last element has left the lane pipeline. It sits between the CV-X-IF issue logic and the first lane pipeline segment.

## Interface
- MAXVL, 32, maximum elements per instruction; longer `req_vl` is clamped to this value.
- VL_W, 6, width of `req_vl`; must satisfy 2^VL_W > MAXVL.
- IDX_W, 5, width of the element index; must satisfy 2^IDX_W >= MAXVL.
- RADDR_W, 5, vector register address width.
- OP_W, 4, operation code width.
- PIPE_DEPTH, 3, number of lane pipeline segments to drain before `done`; must be >= 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  descriptor valid.
- req_ready  out  1  sequencer can accept a descriptor.
- req_vl  in  VL_W  element count.
- req_vd, req_vs1, req_vs2  in  RADDR_W each  register addresses.
- req_op  in  OP_W  operation.
- el_valid  out  1  element valid toward the lane pipeline.
- el_ready  in  1  lane pipeline accepts the element this cycle.
- el_idx  out  IDX_W  element index.
- el_vd, el_vs1, el_vs2  out  RADDR_W  latched addresses.
- el_op  out  OP_W  latched operation.
- el_last  out  1  current element is index vl-1.
- done  out  1  single-cycle completion pulse.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - ISSUE: `el_valid`=1.
  - DRAIN: waiting for the last element to leave the lane pipeline.
- IDLE with `req_valid`=1:
  - Latch the descriptor and set vl_eff = min(req_vl, MAXVL).
  - If vl_eff>0: go to ISSUE with idx=0.
  - If vl_eff=0: go to DRAIN with cnt=1. No elements are issued.
- ISSUE with `el_ready`=1:
  - If idx==vl_eff-1: go to DRAIN with cnt=PIPE_DEPTH.
  - Otherwise: idx+1.
- ISSUE with `el_ready`=0: hold idx and the full payload stable, and keep `el_valid` high.
- DRAIN:
  - cnt decrements every cycle; `el_ready` is ignored.
  - `done`=1 while cnt==1, then go to IDLE.
- `el_last` = (idx==vl_eff-1) && `el_valid`.
- `el_vd`/`el_vs1`/`el_vs2`/`el_op` come from the latched descriptor. Input changes after acceptance have no effect.
- All outputs are registered or decoded from state registers only; no combinational path from `req_*` or `el_ready` to any output.
- `req_ready` is 0 in ISSUE and DRAIN. A descriptor presented then is not accepted and must be held by the source.
- Reset values:
  - State IDLE.
  - `req_ready`=1 from the first cycle after reset deasserts.
  - `el_valid`, `el_last`, `done`, `busy` = 0.
  - `el_idx` and payload = 0.
- Reset mid-operation: the current instruction is abandoned, no `done` is emitted, and the sequencer is back in IDLE on the next cycle.

## Timing
- Accept at cycle T (`req_valid` && `req_ready`): first element appears (`el_valid`=1, idx 0) at T+1.
- With `el_ready` held high, element k appears at T+1+k. The last element handshakes at L = T+vl_eff.
- `done` is high at cycle L+PIPE_DEPTH. `req_ready` returns to 1 at L+PIPE_DEPTH+1.
- Each `el_ready`=0 cycle during ISSUE delays every later event by exactly one cycle.
- vl=0: accept at T, `done` at T+1, `req_ready`=1 at T+2, `el_valid` never asserted.
- Back-to-back instructions: minimum gap from one accept to the next is vl_eff+PIPE_DEPTH+1 cycles.

## Test plan
- Reset, then descriptor vl=4, op=2, vd=1, `el_ready`=1, PIPE_DEPTH=3 accepted at T=0 -> idx 0..3 at cycles 1..4 with `el_last` only at 4; `done` at 7; `req_ready` at 8.
- vl=3 with `el_ready` low at cycles 2 and 3 -> idx 1 held stable for cycles 2-4 with the payload unchanged; idx 2 at 5; `done` at 8.
- vl=0 accepted at T=0 -> `el_valid` never high; `done` at 1; `req_ready` at 2.
- vl=40 with MAXVL=32 -> exactly 32 elements (idx 0..31), `el_last` on idx 31.
- Descriptor inputs changed and `req_valid` held high while busy -> outputs keep the latched values; the second descriptor is accepted only in the cycle `req_ready` returns to 1.
- Reset asserted during ISSUE at idx 2 of vl=8 -> next cycle `el_valid`=0, `busy`=0, `req_ready`=1; no `done` pulse ever follows.
